load_store_unit: RTL

- Initiator side of the data-memory port: takes one load/store request at a time from the execute stage and drives Ena/Wea/Address/DataIn of the word-wide data BRAM.
- Handles the BRAM read latency.
- Performs sign/zero extension for sub-word loads.
- Performs read-modify-write for byte and halfword stores, because the memory has a single whole-word write enable.
- Flags misaligned accesses without touching memory.

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: sub-word load extraction, read-modify-write stores, misalignment errors.
// Optional `LSU_PERF_CNT_EN adds saturating load/store/error response counters.
module load_store_unit #(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W+1:0] ReqAddr,
  input  logic [31:0]       ReqWData,
  output logic              RspValid,
  output logic [31:0]       RspData,
  output logic              RspErr,
  output logic              MemEna,
  output logic              MemWea,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemDataIn,
  input  logic [31:0]       MemDataOut
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0]       LoadCnt,
  output logic [15:0]       StoreCnt,
  output logic [15:0]       ErrCnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RSP} state_t;

  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  state_t      r_state;
  logic [1:0]  r_wait;
  logic        r_write;
  logic        r_err;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        w_accept;
  logic        w_err;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    res[7:0]   = wdata[7:0];
          2'd1:    res[15:8]  = wdata[7:0];
          2'd2:    res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  assign w_accept = ReqValid && ReqReady;
  assign w_err    = (ReqSize == 2'b11) ||
                    ((ReqSize == 2'b01) && ReqAddr[0]) ||
                    ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_wait    <= 2'd0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_signed  <= 1'b0;
      r_size    <= 2'b00;
      r_lane    <= 2'b00;
      r_wdata   <= 32'd0;
      ReqReady  <= 1'b0;
      RspValid  <= 1'b0;
      RspData   <= 32'd0;
      RspErr    <= 1'b0;
      MemEna    <= 1'b0;
      MemWea    <= 1'b0;
      MemAddr   <= '0;
      MemDataIn <= 32'd0;
    end else begin
      // Strobes default low; each state re-asserts what it owns for the next cycle
      ReqReady <= 1'b0;
      RspValid <= 1'b0;
      RspData  <= 32'd0;
      RspErr   <= 1'b0;
      MemEna   <= 1'b0;
      MemWea   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= ReqWrite;
            r_err    <= w_err;
            r_signed <= ReqSigned;
            r_size   <= ReqSize;
            r_lane   <= ReqAddr[1:0];
            r_wdata  <= ReqWData;
            MemAddr  <= ReqAddr[ADDR_W+1:2];
            if (w_err) begin
              r_state  <= S_RSP;
              RspValid <= 1'b1;
              RspErr   <= 1'b1;
            end else if (ReqWrite && (ReqSize == 2'b10)) begin
              r_state   <= S_WR;
              MemEna    <= 1'b1;
              MemWea    <= 1'b1;
              MemDataIn <= ReqWData;
            end else begin
              r_state <= S_RD;
              MemEna  <= 1'b1;
            end
          end else begin
            ReqReady <= 1'b1;
          end
        end
        S_RD: begin
          r_state <= S_WAIT;
          r_wait  <= LAT_M1;
        end
        S_WAIT: begin
          if (r_wait != 2'd0) begin
            r_wait <= r_wait - 2'd1;
          end else if (r_write) begin
            r_state   <= S_WR;
            MemEna    <= 1'b1;
            MemWea    <= 1'b1;
            MemDataIn <= store_merge(MemDataOut, r_wdata, r_size, r_lane);
          end else begin
            r_state  <= S_RSP;
            RspValid <= 1'b1;
            RspData  <= load_extract(MemDataOut, r_size, r_lane, r_signed);
          end
        end
        S_WR: begin
          r_state  <= S_RSP;
          RspValid <= 1'b1;
        end
        S_RSP: begin
          r_state  <= S_IDLE;
          ReqReady <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      LoadCnt  <= 16'd0;
      StoreCnt <= 16'd0;
      ErrCnt   <= 16'd0;
    end else if (r_state == S_RSP) begin
      if (r_err)        ErrCnt   <= sat_inc(ErrCnt);
      else if (r_write) StoreCnt <= sat_inc(StoreCnt);
      else              LoadCnt  <= sat_inc(LoadCnt);
    end
  end
`endif

endmodule
